// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream consumer.
package fifo_rd_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 8;
  localparam int unsigned DEF_LEN_WIDTH  = 8;
  localparam int unsigned STAT_WIDTH     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } rd_state_e;

  // Saturating increment for the statistics counters
  function automatic logic [STAT_WIDTH-1:0] sat_inc(input logic [STAT_WIDTH-1:0] v);
    return (v == '1) ? v : v + STAT_WIDTH'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_skid_buf.sv
// Circular output buffer: push at tail, pop at head, registered occupancy.
module fifo_rd_skid_buf
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned BUF_DEPTH  = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             push,
  input  logic [DATA_WIDTH-1:0]            push_data,
  input  logic                             pop,
  output logic [DATA_WIDTH-1:0]            head_data,
  output logic [$clog2(BUF_DEPTH+1)-1:0]   occ
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);

  logic [DATA_WIDTH-1:0] mem [BUF_DEPTH];
  logic [PTR_W-1:0]      head_q;
  logic [PTR_W-1:0]      tail_q;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  // Storage, pointers and occupancy; simultaneous push/pop leaves occ unchanged
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ    <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[tail_q] <= push_data;
        tail_q      <= ptr_inc(tail_q);
      end
      if (pop) begin
        head_q <= ptr_inc(head_q);
      end
      if (push && !pop) begin
        occ <= occ + OCC_W'(1);
      end else if (pop && !push) begin
        occ <= occ - OCC_W'(1);
      end
    end
  end

  assign head_data = mem[head_q];

endmodule

// File: rtl/fifo_rd_stream.sv
// Pulls a commanded number of words from the async FIFO read port and replays them
// on a valid/ready stream with m_last/done. Optional counters: FIFO_RD_STREAM_STATS_EN.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned LEN_WIDTH  = DEF_LEN_WIDTH,
  parameter int unsigned BUF_DEPTH  = 3
) (
  input  logic                  r_clk,
  input  logic                  r_rst,
  input  logic                  cmd_valid,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  cmd_ready,
  input  logic                  r_empty,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  r_en,
  output logic                  m_valid,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  input  logic                  m_ready,
  output logic                  done,
  output logic                  busy
`ifdef FIFO_RD_STREAM_STATS_EN
  ,
  output logic [STAT_WIDTH-1:0] stat_words,
  output logic [STAT_WIDTH-1:0] stat_empty_stall,
  output logic [STAT_WIDTH-1:0] stat_sink_stall
`endif
);

  localparam int unsigned OCC_W = $clog2(BUF_DEPTH + 1);
  localparam int unsigned CNT_W = OCC_W + 1;

  rd_state_e            state_q, state_d;
  logic [LEN_WIDTH-1:0] issue_left_q, issue_left_d;
  logic [LEN_WIDTH-1:0] out_left_q, out_left_d;
  logic                 inflight_q;
  logic                 done_q, done_d;
  logic [OCC_W-1:0]     occ;
  logic                 has_space;
  logic                 pop;

  // Space check counts the read already in flight, so the buffer cannot overflow
  assign has_space = (CNT_W'(occ) + CNT_W'(inflight_q)) < CNT_W'(BUF_DEPTH);
  assign r_en      = (state_q == RUN) && !r_empty && has_space;

  assign m_valid   = (occ != '0);
  assign pop       = m_valid && m_ready;
  assign m_last    = m_valid && (out_left_q == LEN_WIDTH'(1));
  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign done      = done_q;

  fifo_rd_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_DEPTH  (BUF_DEPTH)
  ) u_buf (
    .clk       (r_clk),
    .rst       (r_rst),
    .push      (inflight_q),
    .push_data (r_data),
    .pop       (pop),
    .head_data (m_data),
    .occ       (occ)
  );

  // State register and command counters
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      state_q      <= IDLE;
      issue_left_q <= '0;
      out_left_q   <= '0;
      inflight_q   <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      issue_left_q <= issue_left_d;
      out_left_q   <= out_left_d;
      inflight_q   <= r_en;
      done_q       <= done_d;
    end
  end

  // Next-state: accept in IDLE, issue reads in RUN, wait for last pop in DRAIN
  always_comb begin
    state_d      = state_q;
    issue_left_d = issue_left_q;
    out_left_d   = out_left_q;
    done_d       = 1'b0;
    if (pop) begin
      out_left_d = out_left_q - LEN_WIDTH'(1);
    end
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && (cmd_len != '0)) begin
          issue_left_d = cmd_len;
          out_left_d   = cmd_len;
          state_d      = RUN;
        end
      end
      RUN: begin
        if (r_en) begin
          issue_left_d = issue_left_q - LEN_WIDTH'(1);
          if (issue_left_q == LEN_WIDTH'(1)) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (pop && (out_left_q == LEN_WIDTH'(1))) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

`ifdef FIFO_RD_STREAM_STATS_EN
  // Saturating activity counters
  always_ff @(posedge r_clk or posedge r_rst) begin
    if (r_rst) begin
      stat_words       <= '0;
      stat_empty_stall <= '0;
      stat_sink_stall  <= '0;
    end else begin
      if (pop) begin
        stat_words <= sat_inc(stat_words);
      end
      if ((state_q == RUN) && r_empty && has_space) begin
        stat_empty_stall <= sat_inc(stat_empty_stall);
      end
      if (m_valid && !m_ready) begin
        stat_sink_stall <= sat_inc(stat_sink_stall);
      end
    end
  end
`endif

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench for fifo_rd_stream: directed table, reset abort and random traffic
// against a queue-based reference model.
module tb_fifo_rd_stream;

  localparam int DW    = 8;
  localparam int LW    = 8;
  localparam int DEPTH = 3;

  logic          r_clk = 1'b0;
  logic          r_rst;
  logic          cmd_valid;
  logic [LW-1:0] cmd_len;
  logic          cmd_ready;
  logic          r_empty;
  logic [DW-1:0] r_data;
  logic          r_en;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic          m_ready;
  logic          done;
  logic          busy;
`ifdef FIFO_RD_STREAM_STATS_EN
  logic [15:0]   stat_words;
  logic [15:0]   stat_empty_stall;
  logic [15:0]   stat_sink_stall;
`endif

  always #5 r_clk = ~r_clk;

  fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .LEN_WIDTH  (LW),
    .BUF_DEPTH  (DEPTH)
  ) dut (
    .r_clk     (r_clk),
    .r_rst     (r_rst),
    .cmd_valid (cmd_valid),
    .cmd_len   (cmd_len),
    .cmd_ready (cmd_ready),
    .r_empty   (r_empty),
    .r_data    (r_data),
    .r_en      (r_en),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_last    (m_last),
    .m_ready   (m_ready),
    .done      (done),
`ifdef FIFO_RD_STREAM_STATS_EN
    .stat_words       (stat_words),
    .stat_empty_stall (stat_empty_stall),
    .stat_sink_stall  (stat_sink_stall),
`endif
    .busy      (busy)
  );

  typedef struct {
    int len;
    int base;
    int fill;
    int ready_stall;
    int empty_after;
    int empty_cycles;
    int busy_cmd;
    int exp_words;
    int exp_ren;
    int exp_first;
    int exp_last;
    int exp_done;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  // Upstream FIFO and reference model state
  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] buf_q[$];
  bit  act;
  int  issue_left, out_left;
  bit  infl, done_m;
  int  force_empty, fifo_pops;
  int  s_words, s_empty, s_sink;
  int  o_words, o_ren, o_done, o_last;
  logic [DW-1:0] o_first, o_lastw;

  task automatic chk(input string name, input logic [31:0] a, input logic [31:0] e);
    compared++;
    if (a !== e) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  task automatic model_reset();
    buf_q.delete();
    act = 1'b0; issue_left = 0; out_left = 0;
    infl = 1'b0; done_m = 1'b0;
    s_words = 0; s_empty = 0; s_sink = 0;
  endtask

  // One clock: compare at negedge, advance model at posedge, update FIFO outputs after it
  task automatic cycle();
    bit idle_now, pop_m, ren_dut, e_ren, e_mv, e_last, space;
    @(negedge r_clk);
    idle_now = !act;
    space    = (buf_q.size() + int'(infl)) < DEPTH;
    e_ren    = act && (issue_left > 0) && !r_empty && space;
    e_mv     = (buf_q.size() != 0);
    e_last   = e_mv && (out_left == 1);
    chk("r_en",      32'(r_en),      32'(e_ren));
    chk("m_valid",   32'(m_valid),   32'(e_mv));
    if (e_mv) chk("m_data", 32'(m_data), 32'(buf_q[0]));
    chk("m_last",    32'(m_last),    32'(e_last));
    chk("cmd_ready", 32'(cmd_ready), 32'(!act));
    chk("busy",      32'(busy),      32'(act));
    chk("done",      32'(done),      32'(done_m));
    if (r_en) o_ren++;
    if (done) o_done++;
    if (m_valid && m_ready) begin
      if (o_words == 0) o_first = m_data;
      o_lastw = m_data;
      o_words++;
      if (m_last) o_last++;
    end
    if (act && (issue_left > 0) && r_empty && space) s_empty++;
    if (e_mv && !m_ready) s_sink++;
    if (e_mv && m_ready) s_words++;
    ren_dut = r_en;
    @(posedge r_clk);
    if (r_rst) begin
      model_reset();
    end else begin
      pop_m  = e_mv && m_ready;
      done_m = pop_m && (out_left == 1);
      if (pop_m) begin
        void'(buf_q.pop_front());
        out_left--;
        if (out_left == 0) act = 1'b0;
      end
      if (infl) buf_q.push_back(r_data);
      if (e_ren) issue_left--;
      infl = e_ren;
      if (idle_now && cmd_valid && (cmd_len != '0)) begin
        act = 1'b1;
        issue_left = int'(cmd_len);
        out_left   = int'(cmd_len);
      end
    end
    #1;
    if (ren_dut && (fifo_q.size() != 0)) begin
      r_data = fifo_q.pop_front();
      fifo_pops++;
    end
    if (force_empty > 0) force_empty--;
    r_empty = (fifo_q.size() == 0) || (force_empty > 0);
  endtask

  task automatic run_vec(input vec_t v);
    int cyc, stall_left, busy_left, ren_before, stall_ren;
    bit accepted, finished, trig, stall_started, was_stall;
`ifdef FIFO_RD_STREAM_STATS_EN
    logic [15:0] sw0, ss0;
    sw0 = stat_words;
    ss0 = stat_sink_stall;
`endif
    cyc = 0; stall_left = 0; busy_left = v.busy_cmd; stall_ren = 0;
    accepted = 0; finished = 0; trig = 0; stall_started = 0;
    fifo_q.delete();
    for (int i = 0; i < v.fill; i++) fifo_q.push_back(DW'(v.base + i));
    o_words = 0; o_ren = 0; o_done = 0; o_last = 0; fifo_pops = 0; force_empty = 0;
    r_empty   = (fifo_q.size() == 0);
    cmd_valid = 1'b1;
    cmd_len   = LW'(v.len);
    while (!finished && (cyc < 300)) begin
      if (!stall_started && (v.ready_stall > 0) && (buf_q.size() != 0)) begin
        stall_started = 1;
        stall_left    = v.ready_stall;
      end
      m_ready    = (stall_left == 0);
      was_stall  = (stall_left > 0);
      ren_before = o_ren;
      cycle();
      cyc++;
      if (was_stall) stall_ren += o_ren - ren_before;
      if (stall_left > 0) stall_left--;
      if (!accepted) begin
        accepted = 1;
        if (v.len != 0) begin
          cmd_valid = (busy_left > 0);
          cmd_len   = LW'(7);
        end
      end else if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) cmd_valid = 1'b0;
      end
      if ((v.empty_after >= 0) && !trig && (fifo_pops == v.empty_after)) begin
        trig        = 1;
        force_empty = v.empty_cycles;
        r_empty     = 1'b1;
      end
      finished = (v.len == 0) ? (cyc >= 6) : (o_done > 0);
    end
    cmd_valid = 1'b0;
    chk("vec completed", 32'(finished), 32'(1));
    chk("vec words",     32'(o_words),  32'(v.exp_words));
    chk("vec r_en count", 32'(o_ren),   32'(v.exp_ren));
    chk("vec done count", 32'(o_done),  32'(v.exp_done));
    chk("vec m_last pops", 32'(o_last), 32'(v.exp_done));
    if (v.exp_words > 0) begin
      chk("vec first word", 32'(o_first), 32'(v.exp_first));
      chk("vec last word",  32'(o_lastw), 32'(v.exp_last));
    end
    if (v.ready_stall > 0) begin
      chk("r_en during stall <= depth", 32'(stall_ren <= DEPTH), 32'(1));
`ifdef FIFO_RD_STREAM_STATS_EN
      chk("stat_sink_stall delta", 32'(stat_sink_stall - ss0), 32'(v.ready_stall));
      chk("stat_words delta",      32'(stat_words - sw0),      32'(v.exp_words));
`endif
    end
  endtask

  vec_t vecs[6];

  initial begin
    int cyc, len;
    logic [DW-1:0] exp0, exp1;

    //            len base fill stall e_aft e_cyc busy words ren first last done
    vecs[0] = '{5,   1,   5,   0,    -1,   0,    0,   5,    5,  1,    5,   1};
    vecs[1] = '{4,   9,   4,   0,     2,   6,    0,   4,    4,  9,    12,  1};
    vecs[2] = '{8,   20,  8,   10,   -1,   0,    4,   8,    8,  20,   27,  1};
    vecs[3] = '{0,   40,  2,   0,    -1,   0,    0,   0,    0,  0,    0,   0};
    vecs[4] = '{1,   50,  1,   0,    -1,   0,    0,   1,    1,  50,   50,  1};
    vecs[5] = '{1,   60,  1,   0,    -1,   0,    0,   1,    1,  60,   60,  1};

    r_rst = 1'b1; cmd_valid = 1'b0; cmd_len = '0; m_ready = 1'b0;
    r_data = '0; r_empty = 1'b1; force_empty = 0; fifo_pops = 0;
    fifo_q.delete();
    model_reset();
    repeat (2) @(posedge r_clk);
    #1;
    chk("reset m_valid",   32'(m_valid),   32'(0));
    chk("reset m_data",    32'(m_data),    32'(0));
    chk("reset m_last",    32'(m_last),    32'(0));
    chk("reset done",      32'(done),      32'(0));
    chk("reset busy",      32'(busy),      32'(0));
    chk("reset cmd_ready", 32'(cmd_ready), 32'(1));
    chk("reset r_en",      32'(r_en),      32'(0));
    r_rst = 1'b0;

    for (int k = 0; k < 6; k++) run_vec(vecs[k]);

    // Reset in the middle of an 8-word command, after 3 words delivered
    fifo_q.delete();
    for (int i = 0; i < 12; i++) fifo_q.push_back(DW'(100 + i));
    r_empty = 1'b0; m_ready = 1'b1; o_words = 0; o_done = 0;
    cmd_valid = 1'b1; cmd_len = LW'(8);
    cycle();
    cmd_valid = 1'b0;
    cyc = 0;
    while ((o_words < 3) && (cyc < 50)) begin
      cycle();
      cyc++;
    end
    chk("abort reached 3 words", 32'(o_words), 32'(3));
    r_rst = 1'b1;
    #1;
    chk("async reset m_valid",   32'(m_valid),   32'(0));
    chk("async reset busy",      32'(busy),      32'(0));
    chk("async reset cmd_ready", 32'(cmd_ready), 32'(1));
    chk("async reset r_en",      32'(r_en),      32'(0));
    model_reset();
    cycle();
    r_rst = 1'b0;
    exp0 = fifo_q[0];
    exp1 = fifo_q[1];
    o_words = 0; o_done = 0;
    cmd_valid = 1'b1; cmd_len = LW'(2);
    cycle();
    cmd_valid = 1'b0;
    cyc = 0;
    while ((o_done == 0) && (cyc < 50)) begin
      cycle();
      cyc++;
    end
    chk("post-reset done",  32'(o_done),  32'(1));
    chk("post-reset words", 32'(o_words), 32'(2));
    chk("post-reset word0", 32'(o_first), 32'(exp0));
    chk("post-reset word1", 32'(o_lastw), 32'(exp1));

    // Random commands with random sink backpressure and FIFO empty gaps
    for (int n = 0; n < 40; n++) begin
      len = ((n % 10) == 9) ? int'($urandom_range(100, 255)) : int'($urandom_range(1, 24));
      fifo_q.delete();
      for (int i = 0; i < len; i++) fifo_q.push_back(DW'($urandom));
      force_empty = 0;
      r_empty = 1'b0;
      cmd_valid = 1'b0;
      m_ready = 1'b1;
      repeat ($urandom_range(0, 2)) cycle();
      cmd_valid = 1'b1;
      cmd_len = LW'(len);
      o_done = 0;
      cyc = 0;
      while ((o_done == 0) && (cyc < 2000)) begin
        m_ready = ($urandom_range(0, 3) != 0);
        if ((force_empty == 0) && ($urandom_range(0, 7) == 0)) begin
          force_empty = $urandom_range(1, 4);
          r_empty = 1'b1;
        end
        cycle();
        cyc++;
        if (act && (out_left > 1) && ($urandom_range(0, 3) == 0)) begin
          cmd_valid = 1'b1;
          cmd_len   = LW'($urandom);
        end else begin
          cmd_valid = 1'b0;
        end
      end
      chk("random command done", 32'(o_done), 32'(1));
    end
    cmd_valid = 1'b0;

`ifdef FIFO_RD_STREAM_STATS_EN
    chk("stat_words",       32'(stat_words),       32'(s_words));
    chk("stat_empty_stall", 32'(stat_empty_stall), 32'(s_empty));
    chk("stat_sink_stall",  32'(stat_sink_stall),  32'(s_sink));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
